ui_level_ctrl: RTL and testbench
================================

UI_LEVEL_CTRL -- requirements
Module: ui_level_ctrl

Interface
REQ-001 SHALL have parameter N_BTN, default 2, number of active-low push-buttons (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 540000, required consecutive stable cycles before a debounced change.
REQ-003 SHALL have parameter LONG_CYCLES, default 27000000, debounced hold length that counts as a long press.
REQ-004 SHALL have parameter N_LEVELS, default 4, number of selectable levels (2..16).
REQ-005 SHALL have parameter LEVEL_TABLE, default {0,20,50,100}, N_LEVELS entries of NOISE_MAG_WIDTH bits each.
REQ-006 SHALL have parameter WRAP, default 1; 1 = wrap-around, 0 = saturate at the ends.
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port rst, input, 1 bit, with the decided reset: one clock; reset is synchronous and active-high.
REQ-009 SHALL have port btn_n, input, N_BTN bits, raw asynchronous buttons, 0 = pressed.
REQ-010 SHALL have port btn_state, output, N_BTN bits, debounced level, 1 = pressed.
REQ-011 SHALL have port press_pulse, output, N_BTN bits, one-cycle pulse on the debounced press edge.
REQ-012 SHALL have port long_pulse, output, N_BTN bits, one-cycle pulse when a hold reaches LONG_CYCLES.
REQ-013 SHALL have port level_sel, output, clog2(N_LEVELS) bits, current level index.
REQ-014 SHALL have port level_value, output, NOISE_MAG_WIDTH bits, LEVEL_TABLE[level_sel], registered.

Function
REQ-015 Each btn_n bit SHALL pass through a 2-FF synchroniser; the synchroniser reset value is 1 (released).
REQ-016 Per button, a counter SHALL increment each cycle the synchronised value differs from btn_state; it clears when they agree.
REQ-017 btn_state SHALL toggle on the cycle the counter reaches DEBOUNCE_CYCLES-1, and the counter clears.
REQ-018 A clean input edge SHALL cause the btn_state change, and any press_pulse, DEBOUNCE_CYCLES+2 cycles after the first edge that samples it.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no btn_state change.
REQ-020 Each button SHALL run an FSM: RELEASED -> HELD on debounced press, with press_pulse.
REQ-021 In HELD, a hold counter SHALL count up; HELD -> LONG when the count equals LONG_CYCLES-1, with long_pulse.
REQ-022 HELD or LONG -> RELEASED on debounced release; long_pulse fires at most once per press.
REQ-023 Button 0 press SHALL increment level_sel and button 1 press SHALL decrement it; buttons 2 and above generate pulses only.
REQ-024 When N_BTN = 1, there SHALL be no decrement path.
REQ-025 At the ends of the range, WRAP=1 SHALL wrap N_LEVELS-1 -> 0 and 0 -> N_LEVELS-1; WRAP=0 SHALL hold the value.
REQ-026 A long_pulse on button 0 SHALL force level_sel to 0 and take priority over any press event in the same cycle.
REQ-027 Increment and decrement in the same cycle SHALL leave level_sel unchanged.
REQ-028 level_sel SHALL update 1 cycle after the pulse; level_value SHALL follow 1 cycle after level_sel.

Reset
REQ-029 On rst=1 at a clk edge, the block SHALL set btn_state=0, press_pulse=0, long_pulse=0, level_sel=0, level_value=LEVEL_TABLE[0], all counters=0 and all FSMs=RELEASED.
REQ-030 A reset asserted while a button is held SHALL produce no pulse after release of rst until a new debounced press occurs.

Structure
REQ-031 NOISE_MAG_WIDTH and the default level table SHALL live in gdsp_pkg; the FSM state typedef SHALL be local to the module.
REQ-032 The per-button synchroniser, debounce and FSM SHALL be a sub-module btn_debounce, instantiated N_BTN times by generate.

Verification
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=16, N_LEVELS=4, table {0,20,50,100}.
REQ-033 Clean press on btn 0 at cycle 0 -> press_pulse[0] high at cycle 6 only; level_sel=1 at cycle 7; level_value=20 at cycle 8.
REQ-034 3-cycle low glitch on btn 0 -> no btn_state change and no pulse.
REQ-035 Four btn 0 presses with WRAP=1 -> level_value sequence 20, 50, 100, 0; with WRAP=0 -> level stays at 100.
REQ-036 Btn 0 held 40 cycles -> exactly one press_pulse, one long_pulse 16 cycles after it, and level_sel=0.
REQ-037 Both buttons pressed on the same cycle from level 2 -> both pulses fire and level_sel stays 2.
REQ-038 rst asserted mid-hold, then button released -> all outputs at reset values and no pulses.

Source files
------------

// File: rtl/gdsp_pkg.sv
// Shared constants for the level controller: table entry width, the default
// level table, and the index stepping rule used for up/down selection.
package gdsp_pkg;

  localparam int NOISE_MAG_WIDTH = 8;
  localparam int DEFAULT_N_LEVELS = 4;

  // Entry 0 is the most significant slice, so the literal reads in index order.
  localparam logic [DEFAULT_N_LEVELS*NOISE_MAG_WIDTH-1:0] DEFAULT_LEVEL_TABLE =
    {8'd0, 8'd20, 8'd50, 8'd100};

  function automatic int step_level(input int cur, input bit up, input int n, input bit wrap);
    int nxt;
    if (up) begin
      if (cur == n - 1) nxt = wrap ? 0 : cur;
      else              nxt = cur + 1;
    end else begin
      if (cur == 0) nxt = wrap ? n - 1 : cur;
      else          nxt = cur - 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, stability-count debounce, and the
// press/long-press FSM with registered pulse outputs.
//
// state    | meaning
// RELEASED | debounced level is released, waiting for a press
// HELD     | pressed, hold counter running towards a long press
// LONG     | long press already reported, waiting for release
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 540000,
  parameter int LONG_CYCLES     = 27000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_state,
  output logic press_pulse,
  output logic long_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    LONG     = 2'd2
  } state_t;

  logic            sync1;
  logic            sync2;
  logic            pressed_raw;
  logic            level;
  logic [DB_W-1:0] db_cnt;
  logic [LG_W-1:0] hold_cnt;
  state_t          state;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign pressed_raw = ~sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (pressed_raw != level) begin
      if (db_cnt == DB_LAST) begin
        level  <= ~level;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // btn_state is re-registered so it changes on the same edge as press_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RELEASED;
      hold_cnt    <= '0;
      btn_state   <= 1'b0;
      press_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      btn_state   <= level;
      case (state)
        RELEASED: begin
          hold_cnt <= '0;
          if (level) begin
            state       <= HELD;
            press_pulse <= 1'b1;
          end
        end
        HELD: begin
          if (!level) begin
            state    <= RELEASED;
            hold_cnt <= '0;
          end else if (hold_cnt == LG_LAST) begin
            state      <= LONG;
            long_pulse <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (!level) state <= RELEASED;
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/ui_level_ctrl.sv
// User-interface level selector: debounced buttons step a level index up/down
// through a lookup table; a long press on button 0 returns to level 0.
module ui_level_ctrl
  import gdsp_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 540000,
  parameter int LONG_CYCLES     = 27000000,
  parameter int N_LEVELS        = DEFAULT_N_LEVELS,
  parameter logic [N_LEVELS*NOISE_MAG_WIDTH-1:0] LEVEL_TABLE = DEFAULT_LEVEL_TABLE,
  parameter bit WRAP            = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BTN-1:0]             btn_n,
  output logic [N_BTN-1:0]             btn_state,
  output logic [N_BTN-1:0]             press_pulse,
  output logic [N_BTN-1:0]             long_pulse,
  output logic [$clog2(N_LEVELS)-1:0]  level_sel,
  output logic [NOISE_MAG_WIDTH-1:0]   level_value
);

  localparam int SEL_W = $clog2(N_LEVELS);

  logic [NOISE_MAG_WIDTH-1:0] table_arr [N_LEVELS];
  logic inc;
  logic dec;
  logic clr;

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_btn (
      .clk        (clk),
      .rst        (rst),
      .btn_n      (btn_n[b]),
      .btn_state  (btn_state[b]),
      .press_pulse(press_pulse[b]),
      .long_pulse (long_pulse[b])
    );
  end

  for (genvar i = 0; i < N_LEVELS; i++) begin : g_table
    assign table_arr[i] = LEVEL_TABLE[(N_LEVELS-1-i)*NOISE_MAG_WIDTH +: NOISE_MAG_WIDTH];
  end

  assign inc = press_pulse[0];
  assign clr = long_pulse[0];

  if (N_BTN > 1) begin : g_dec
    assign dec = press_pulse[1];
  end else begin : g_no_dec
    assign dec = 1'b0;
  end

  // Long press on button 0 wins over any press in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_sel   <= '0;
      level_value <= table_arr[0];
    end else begin
      if (clr) begin
        level_sel <= '0;
      end else if (inc && !dec) begin
        level_sel <= SEL_W'(step_level(int'(level_sel), 1'b1, N_LEVELS, WRAP));
      end else if (dec && !inc) begin
        level_sel <= SEL_W'(step_level(int'(level_sel), 1'b0, N_LEVELS, WRAP));
      end
      level_value <= table_arr[level_sel];
    end
  end

endmodule

// File: tb/tb_ui_level_ctrl.sv
// Bench for ui_level_ctrl: a wrapping and a saturating instance share the
// button inputs; pulses are scoreboarded, levels checked from a vector table.
module tb_ui_level_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn_n = 2'b11;

  logic [1:0] bs_w, pp_w, lp_w, sel_w;
  logic [1:0] bs_s, pp_s, lp_s, sel_s;
  logic [7:0] val_w, val_s;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    int kind;  // 0 = press, 1 = long
    int btn;
  } exp_t;

  typedef struct {
    logic [1:0] mask;
    int hold;
    int sel_w;
    int val_w;
    int sel_s;
    int val_s;
  } vec_t;

  exp_t q_w[$];
  exp_t q_s[$];
  vec_t vecs[9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ui_level_ctrl #(
    .N_BTN(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(16), .N_LEVELS(4),
    .LEVEL_TABLE({8'd0, 8'd20, 8'd50, 8'd100}), .WRAP(1'b1)
  ) dut_w (
    .clk(clk), .rst(rst), .btn_n(btn_n), .btn_state(bs_w),
    .press_pulse(pp_w), .long_pulse(lp_w), .level_sel(sel_w), .level_value(val_w)
  );

  ui_level_ctrl #(
    .N_BTN(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(16), .N_LEVELS(4),
    .LEVEL_TABLE({8'd0, 8'd20, 8'd50, 8'd100}), .WRAP(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .btn_n(btn_n), .btn_state(bs_s),
    .press_pulse(pp_s), .long_pulse(lp_s), .level_sel(sel_s), .level_value(val_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, req);
    end
  endtask

  task automatic check_event(input int k, input int kind, input int b, input bit empty, input exp_t e);
    checks++;
    if (empty) begin
      failures++;
      $display("FAIL unexpected_pulse dut=%0d kind=%0d btn=%0d cyc=%0d expected=none", k, kind, b, cyc);
    end else if (e.cyc != cyc || e.kind != kind || e.btn != b) begin
      failures++;
      $display("FAIL pulse dut=%0d got cyc=%0d kind=%0d btn=%0d expected cyc=%0d kind=%0d btn=%0d",
               k, cyc, kind, b, e.cyc, e.kind, e.btn);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic hit;
    bit   empty;
    for (int k = 0; k < 2; k++) begin
      for (int kind = 0; kind < 2; kind++) begin
        for (int b = 0; b < 2; b++) begin
          if (k == 0) hit = (kind == 0) ? pp_w[b] : lp_w[b];
          else        hit = (kind == 0) ? pp_s[b] : lp_s[b];
          if (hit === 1'b1) begin
            e = '{cyc: -1, kind: -1, btn: -1};
            if (k == 0) begin
              empty = (q_w.size() == 0);
              if (!empty) e = q_w.pop_front();
            end else begin
              empty = (q_s.size() == 0);
              if (!empty) e = q_s.pop_front();
            end
            check_event(k, kind, b, empty, e);
          end
        end
      end
    end
  end

  task automatic push_exp(input int c, input int kind, input int b);
    exp_t e;
    e = '{cyc: c, kind: kind, btn: b};
    q_w.push_back(e);
    q_s.push_back(e);
  endtask

  task automatic check_drained(input string name);
    chk({name, "_pending_w"}, q_w.size(), 0);
    chk({name, "_pending_s"}, q_s.size(), 0);
    q_w.delete();
    q_s.delete();
  endtask

  // Input changes at a negedge are first sampled on the next posedge, so the
  // press pulse is seen 7 negedges after the drive and a long pulse 16 later.
  task automatic do_press(input logic [1:0] mask, input int hold);
    int d;
    @(negedge clk);
    d = cyc;
    btn_n = ~mask;
    for (int b = 0; b < 2; b++) if (mask[b]) push_exp(d + 7, 0, b);
    if (hold >= 20) for (int b = 0; b < 2; b++) if (mask[b]) push_exp(d + 23, 1, b);
    repeat (hold) @(negedge clk);
    btn_n = 2'b11;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int d;
    bit seen;

    vecs[0] = '{2'b01,  8, 2,  50, 2,  50};
    vecs[1] = '{2'b01,  8, 3, 100, 3, 100};
    vecs[2] = '{2'b01,  8, 0,   0, 3, 100};
    vecs[3] = '{2'b10,  8, 3, 100, 2,  50};
    vecs[4] = '{2'b10,  8, 2,  50, 1,  20};
    vecs[5] = '{2'b11,  8, 2,  50, 1,  20};
    vecs[6] = '{2'b01, 40, 0,   0, 0,   0};
    vecs[7] = '{2'b10,  8, 3, 100, 0,   0};
    vecs[8] = '{2'b10, 40, 2,  50, 0,   0};

    repeat (3) @(negedge clk);
    chk("rst_btn_state", {30'd0, bs_w}, 0);
    chk("rst_press", {30'd0, pp_w}, 0);
    chk("rst_long", {30'd0, lp_w}, 0);
    chk("rst_sel_w", {30'd0, sel_w}, 0);
    chk("rst_val_w", {24'd0, val_w}, 0);
    chk("rst_sel_s", {30'd0, sel_s}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press: pulse at cycle 6, level_sel at 7, level_value at 8.
    @(negedge clk);
    d = cyc;
    btn_n = 2'b10;
    push_exp(d + 7, 0, 0);
    repeat (6) @(negedge clk);
    chk("clean_press_c6_pulse", {31'd0, pp_w[0]}, 0);
    chk("clean_press_c6_state", {31'd0, bs_w[0]}, 0);
    @(negedge clk);
    chk("clean_press_c7_pulse", {31'd0, pp_w[0]}, 1);
    chk("clean_press_c7_state", {31'd0, bs_w[0]}, 1);
    chk("clean_press_c7_sel", {30'd0, sel_w}, 0);
    @(negedge clk);
    chk("clean_press_c8_pulse", {31'd0, pp_w[0]}, 0);
    chk("clean_press_c8_sel", {30'd0, sel_w}, 1);
    chk("clean_press_c8_val", {24'd0, val_w}, 0);
    @(negedge clk);
    chk("clean_press_c9_val", {24'd0, val_w}, 20);
    btn_n = 2'b11;
    repeat (12) @(negedge clk);
    chk("clean_release_state", {30'd0, bs_w}, 0);
    check_drained("clean_press");

    // Three-cycle glitch must not move the debounced level.
    @(negedge clk);
    btn_n = 2'b10;
    repeat (3) @(negedge clk);
    btn_n = 2'b11;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bs_w[0] !== 1'b0) seen = 1'b1;
    end
    chk("glitch_state_seen", {31'd0, seen}, 0);
    chk("glitch_sel", {30'd0, sel_w}, 1);
    check_drained("glitch");

    for (int i = 0; i < 9; i++) begin
      do_press(vecs[i].mask, vecs[i].hold);
      chk($sformatf("vec%0d_sel_w", i), {30'd0, sel_w}, vecs[i].sel_w);
      chk($sformatf("vec%0d_val_w", i), {24'd0, val_w}, vecs[i].val_w);
      chk($sformatf("vec%0d_sel_s", i), {30'd0, sel_s}, vecs[i].sel_s);
      chk($sformatf("vec%0d_val_s", i), {24'd0, val_s}, vecs[i].val_s);
      check_drained($sformatf("vec%0d", i));
    end

    // Reset during a hold, button released while in reset: nothing may fire.
    @(negedge clk);
    d = cyc;
    btn_n = 2'b10;
    push_exp(d + 7, 0, 0);
    repeat (12) @(negedge clk);
    chk("midhold_state", {31'd0, bs_w[0]}, 1);
    chk("midhold_sel_w", {30'd0, sel_w}, 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    btn_n = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_state_w", {30'd0, bs_w}, 0);
    chk("midrst_state_s", {30'd0, bs_s}, 0);
    chk("midrst_sel_w", {30'd0, sel_w}, 0);
    chk("midrst_val_w", {24'd0, val_w}, 0);
    chk("midrst_sel_s", {30'd0, sel_s}, 0);
    chk("midrst_val_s", {24'd0, val_s}, 0);
    check_drained("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
